// File: rtl/ifetch_queue_pkg.sv
// ifetch_queue_pkg: core-wide fetch constants shared by the fetch queue slice.
package ifetch_queue_pkg;
  localparam int IM_ADDR_BIT = 8;
  localparam int INSTR_BIT   = 32;
  localparam int IFQ_DEPTH   = 4;
endpackage

// File: rtl/ifetch_queue_fifo_mem.sv
// ifq_fifo_mem: fetch-queue storage, synchronous write, combinational read, no reset.
module ifq_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 40,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [PW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: PC-driven instruction fetch queue with redirect flush.
// Define IFQ_BYPASS_EN to present a response to decode in its arrival cycle when the queue is empty.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH  = IFQ_DEPTH,
  parameter int ADDR_W = IM_ADDR_BIT,
  parameter int DATA_W = INSTR_BIT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [ADDR_W-1:0]          pc,
  output logic                       pc_en,
  output logic                       im_rd,
  output logic [ADDR_W-1:0]          im_addr,
  input  logic [DATA_W-1:0]          im_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [DATA_W-1:0]          out_instr,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic inflight_q;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [ADDR_W+DATA_W-1:0] rdata;
  logic resp, byp, push, fifo_pop;
  // Issue is bounded by occupancy plus the outstanding read, so a response always has a free slot.
  assign pc_en   = rst_n && (flush || (count_q + CW'(inflight_q) < CW'(DEPTH)));
  assign im_rd   = pc_en && !flush;
  assign im_addr = pc;
  assign resp    = inflight_q && !flush;
`ifdef IFQ_BYPASS_EN
  assign byp = resp && (count_q == '0);
`else
  assign byp = 1'b0;
`endif
  assign out_valid = ((count_q != '0) || byp) && !flush;
  assign {out_pc, out_instr} = byp ? {inflight_pc_q, im_data} : rdata;
  assign push     = resp && !(byp && out_ready);
  assign fifo_pop = out_valid && out_ready && !byp;
  assign count    = count_q;
  always_comb begin
    count_d       = flush ? '0 : count_q + CW'(push) - CW'(fifo_pop);
    wr_ptr_d      = flush ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d      = flush ? '0 : rd_ptr_q + PW'(fifo_pop);
    inflight_pc_d = im_rd ? pc : inflight_pc_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      inflight_q    <= im_rd;
      inflight_pc_q <= inflight_pc_d;
    end
  ifq_fifo_mem #(.DEPTH(DEPTH), .W(ADDR_W + DATA_W)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata ({inflight_pc_q, im_data}),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed vectors for the fetch queue against a PC register and 1-cycle memory model.
module tb_ifetch_queue;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [7:0] pc, tgt = 8'h0, im_addr, out_pc;
  logic [31:0] im_data = 32'h0, out_instr;
  logic pc_en, im_rd, out_valid;
  logic [2:0] count;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    bit rst, rdy, fl;
    logic [7:0] tgt;
    bit ev;
    logic [7:0] epc;
    logic [2:0] ecnt;
    bit epcen;
  } vec_t;
  vec_t v[$];
  always #5 clk = ~clk;
  ifetch_queue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .pc(pc), .pc_en(pc_en), .im_rd(im_rd),
    .im_addr(im_addr), .im_data(im_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .count(count)
  );
  always @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= 8'h0;
    else if (pc_en) pc <= flush ? tgt : pc + 8'h1;
  always @(posedge clk)
    if (im_rd) im_data <= 32'h100 + 32'(im_addr);
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic add(input bit rst, rdy, fl, input logic [7:0] t, input bit ev,
                     input logic [7:0] epc, input logic [2:0] ecnt, input bit epcen);
    v.push_back('{rst, rdy, fl, t, ev, epc, ecnt, epcen});
  endtask
  task automatic step(input bit rdy, fl, input logic [7:0] t);
    @(negedge clk);
    rst_n = 1'b1; out_ready = rdy; flush = fl; tgt = t;
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #1;
  endtask
  task automatic wait_valid(input string nm, input logic [7:0] epc);
    int k = 0;
    while (!out_valid && k < 8) begin
      step(1'b1, 1'b0, 8'h0);
      k++;
    end
    chk({nm, " valid"}, 32'(out_valid), 32'h1);
    if (out_valid) begin
      chk({nm, " pc"}, 32'(out_pc), 32'(epc));
      chk({nm, " instr"}, out_instr, 32'h100 + 32'(epc));
    end
  endtask
  initial begin
    // steady flow from reset
    add(1,0,0,0, 0,0,0,0);
    add(0,1,0,0, 0,0,0,1); add(0,1,0,0, 0,0,0,1);
    for (int i = 0; i < 4; i++) add(0,1,0,0, 1,8'(i),1,1);
    // back-pressure fill and release
    add(1,0,0,0, 0,0,0,0);
    add(0,0,0,0, 0,0,0,1); add(0,0,0,0, 0,0,0,1);
    add(0,0,0,0, 1,0,1,1); add(0,0,0,0, 1,0,2,1); add(0,0,0,0, 1,0,3,0);
    for (int i = 0; i < 5; i++) add(0,0,0,0, 1,0,4,0);
    add(0,1,0,0, 1,0,4,0); add(0,1,0,0, 1,1,3,1);
    for (int i = 2; i < 6; i++) add(0,1,0,0, 1,8'(i),2,1);
    // flush at pc 7 with three queued
    add(1,0,0,0, 0,0,0,0);
    add(0,1,0,0, 0,0,0,1); add(0,1,0,0, 0,0,0,1);
    for (int i = 0; i < 3; i++) add(0,1,0,0, 1,8'(i),1,1);
    add(0,0,0,0, 1,3,1,1); add(0,0,0,0, 1,3,2,1);
    add(0,0,1,8'h20, 0,0,3,1);
    add(0,1,0,0, 0,0,0,1); add(0,1,0,0, 0,0,0,1);
    add(0,1,0,0, 1,8'h20,1,1); add(0,1,0,0, 1,8'h21,1,1);
    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk);
      rst_n = !v[i].rst; out_ready = v[i].rdy; flush = v[i].fl; tgt = v[i].tgt;
      #1;
      chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(v[i].ev));
      chk($sformatf("row%0d count", i), 32'(count), 32'(v[i].ecnt));
      chk($sformatf("row%0d pc_en", i), 32'(pc_en), 32'(v[i].epcen));
      chk($sformatf("row%0d im_rd", i), 32'(im_rd), 32'(v[i].epcen && !v[i].fl));
      if (v[i].ev) begin
        chk($sformatf("row%0d out_pc", i), 32'(out_pc), 32'(v[i].epc));
        chk($sformatf("row%0d out_instr", i), out_instr, 32'h100 + 32'(v[i].epc));
      end
    end
    // flush coincident with a ready decode and two queued
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h0);
    step(1'b1, 1'b1, 8'h40);
    chk("flushrdy count_pre", 32'(count), 32'h2);
    chk("flushrdy out_valid", 32'(out_valid), 32'h0);
    step(1'b1, 1'b0, 8'h0);
    chk("flushrdy count_post", 32'(count), 32'h0);
    chk("flushrdy out_valid_post", 32'(out_valid), 32'h0);
    wait_valid("flushrdy first", 8'h40);
    // asynchronous reset with three queued and one in flight
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h0);
    step(1'b0, 1'b0, 8'h0);
    chk("midrst count_pre", 32'(count), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst count", 32'(count), 32'h0);
    chk("midrst out_valid", 32'(out_valid), 32'h0);
    chk("midrst pc_en", 32'(pc_en), 32'h0);
    step(1'b1, 1'b0, 8'h0);
    wait_valid("midrst first", 8'h0);
    step(1'b1, 1'b0, 8'h0);
    chk("midrst second pc", 32'(out_pc), 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
